// File: rtl/axi_sram_slave_if.sv
// AXI channel bundle without ID fields, used between the SRAM slave and its masters.
interface axi_sram_slave_if;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    output rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );

  modport slave_no_id (
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    input  rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_sram_slave.sv
// Single-port AXI slave over a 64-bit SRAM array; one read or write burst in flight at a time,
// with per-beat range checking and SLVERR for out-of-range beats and unsupported burst types.
module axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096
) (
  input  logic                   clock,
  input  logic                   reset,
  axi_sram_slave_if.slave_no_id  axi_bus
);
  localparam int          IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] MEM_BYTES   = 32'(DEPTH_WORDS * 8);
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  RESP_OKEY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_beat;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic        r_err;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic [63:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        r_rlast;
  logic [63:0] r_mem [DEPTH_WORDS];

  function automatic logic inRange(input logic [31:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] wordIdx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return off[3 +: IDX_W];
  endfunction

  function automatic logic badBurst(input logic [1:0] b);
    return !(b == BURST_FIXED || b == BURST_INCR);
  endfunction

  function automatic logic [31:0] nextAddr(input logic [31:0] a, input logic [2:0] s,
                                           input logic [1:0] b);
    return (b == BURST_INCR) ? a + (32'd1 << s) : a;
  endfunction

  logic        w_awFire, w_arFire, w_wFire, w_rFire;
  logic        w_wrBeatBad;
  logic [31:0] w_rdNextAddr;
  logic [31:0] w_ldAddr;
  logic [1:0]  w_ldBurst;
  logic        w_ldBad;
  logic [63:0] w_ldData;
  logic        w_unused;

  assign axi_bus.awready = (r_state == IDLE);
  assign axi_bus.arready = (r_state == IDLE) && !axi_bus.awvalid;
  assign axi_bus.wready  = (r_state == WR_DATA);
  assign axi_bus.bvalid  = r_bvalid;
  assign axi_bus.bresp   = r_bresp;
  assign axi_bus.rvalid  = r_rvalid;
  assign axi_bus.rdata   = r_rdata;
  assign axi_bus.rresp   = r_rresp;
  assign axi_bus.rlast   = r_rlast;

  // Bursts end on the beat count alone, so wlast carries no information here.
  assign w_unused = axi_bus.wlast;

  assign w_awFire     = axi_bus.awvalid && axi_bus.awready;
  assign w_arFire     = axi_bus.arvalid && axi_bus.arready;
  assign w_wFire      = axi_bus.wvalid && axi_bus.wready;
  assign w_rFire      = r_rvalid && axi_bus.rready;
  assign w_wrBeatBad  = badBurst(r_burst) || !inRange(r_addr);
  assign w_rdNextAddr = nextAddr(r_addr, r_size, r_burst);

  // The read data register is loaded either with beat 0 from AR or with the following beat.
  assign w_ldAddr  = (r_state == IDLE) ? axi_bus.araddr  : w_rdNextAddr;
  assign w_ldBurst = (r_state == IDLE) ? axi_bus.arburst : r_burst;
  assign w_ldBad   = badBurst(w_ldBurst) || !inRange(w_ldAddr);
  assign w_ldData  = w_ldBad ? 64'd0 : r_mem[wordIdx(w_ldAddr)];

  always_ff @(posedge clock) begin
    if (!reset && w_wFire && !w_wrBeatBad) begin
      for (int b = 0; b < 8; b++) begin
        if (axi_bus.wstrb[b]) r_mem[wordIdx(r_addr)][8*b +: 8] <= axi_bus.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_err    <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKEY;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKEY;
      r_rlast  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_awFire) begin
            r_addr  <= axi_bus.awaddr;
            r_len   <= axi_bus.awlen;
            r_size  <= axi_bus.awsize;
            r_burst <= axi_bus.awburst;
            r_beat  <= '0;
            r_err   <= 1'b0;
            r_state <= WR_DATA;
          end else if (w_arFire) begin
            r_addr   <= axi_bus.araddr;
            r_len    <= axi_bus.arlen;
            r_size   <= axi_bus.arsize;
            r_burst  <= axi_bus.arburst;
            r_beat   <= '0;
            r_rvalid <= 1'b1;
            r_rdata  <= w_ldData;
            r_rresp  <= w_ldBad ? RESP_SLVERR : RESP_OKEY;
            r_rlast  <= (axi_bus.arlen == 8'd0);
            r_state  <= RD_DATA;
          end
        end
        WR_DATA: begin
          if (w_wFire) begin
            r_addr <= w_rdNextAddr;
            r_beat <= r_beat + 8'd1;
            if (w_wrBeatBad) r_err <= 1'b1;
            if (r_beat == r_len) begin
              r_bvalid <= 1'b1;
              r_bresp  <= (r_err || w_wrBeatBad) ? RESP_SLVERR : RESP_OKEY;
              r_state  <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (axi_bus.bready) begin
            r_bvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        RD_DATA: begin
          if (w_rFire) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_state  <= IDLE;
            end else begin
              r_addr  <= w_rdNextAddr;
              r_beat  <= r_beat + 8'd1;
              r_rdata <= w_ldData;
              r_rresp <= w_ldBad ? RESP_SLVERR : RESP_OKEY;
              r_rlast <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed and randomized bench for axi_sram_slave against an array-based memory model
// that derives each beat's address, range status and data from the burst parameters.
module tb_axi_sram_slave;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          DEPTH   = 4;
  localparam logic [1:0]  OKEY    = 2'b00;
  localparam logic [1:0]  SLVERR  = 2'b10;
  localparam logic [1:0]  FIXED   = 2'b00;
  localparam logic [1:0]  INCR    = 2'b01;
  localparam logic [1:0]  WRAP    = 2'b10;
  localparam int          TIMEOUT = 40;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;

  logic [63:0] model [DEPTH];
  logic [63:0] saved [DEPTH];
  logic [63:0] wrData [256];
  logic [7:0]  wrStrb [256];
  logic [63:0] rdObs [256];
  logic [1:0]  rdRespObs [256];
  logic [1:0]  bObs;
  int          waitCycles;

  axi_sram_slave_if bus();

  axi_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clock   (clock),
    .reset   (reset),
    .axi_bus (bus)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] beatAddr(input logic [31:0] a, input logic [2:0] size,
                                           input logic [1:0] burst, input int i);
    return (burst == FIXED) ? a : a + 32'(i) * (32'd1 << size);
  endfunction

  function automatic bit beatOk(input logic [31:0] a, input logic [1:0] burst);
    logic [63:0] x, lo, hi;
    x  = {32'b0, a};
    lo = {32'b0, BASE};
    hi = lo + 64'(DEPTH * 8);
    return (burst == FIXED || burst == INCR) && x >= lo && x < hi;
  endfunction

  function automatic int modelIdx(input logic [31:0] a);
    return int'(({32'b0, a} - {32'b0, BASE}) >> 3);
  endfunction

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " awready"}, 64'(bus.awready), 64'd1);
    checkOutput({tag, " arready"}, 64'(bus.arready), 64'd1);
    checkOutput({tag, " wready"},  64'(bus.wready),  64'd0);
    checkOutput({tag, " bvalid"},  64'(bus.bvalid),  64'd0);
    checkOutput({tag, " bresp"},   64'(bus.bresp),   64'(OKEY));
    checkOutput({tag, " rvalid"},  64'(bus.rvalid),  64'd0);
    checkOutput({tag, " rdata"},   bus.rdata,        64'd0);
    checkOutput({tag, " rresp"},   64'(bus.rresp),   64'(OKEY));
    checkOutput({tag, " rlast"},   64'(bus.rlast),   64'd0);
  endtask

  // Full write transaction; called and returns just after a rising edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input int bStall, output int awWait);
    logic [1:0] expResp;
    logic [31:0] a;
    int idx;
    expResp = OKEY;
    for (int i = 0; i <= int'(len); i++) begin
      if (!beatOk(beatAddr(addr, size, burst, i), burst)) expResp = SLVERR;
    end
    bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
    awWait = 0;
    @(negedge clock);
    while (!bus.awready && awWait < TIMEOUT) begin awWait++; @(negedge clock); end
    checkOutput("awready", 64'(bus.awready), 64'd1);
    @(posedge clock); #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata = wrData[i]; bus.wstrb = wrStrb[i]; bus.wvalid = 1'b1;
      bus.wlast = (i == int'(len)) ^ ($urandom_range(0, 3) == 0);
      @(negedge clock);
      checkOutput("wready", 64'(bus.wready), 64'd1);
      checkOutput("arready in write", 64'(bus.arready), 64'd0);
      checkOutput("bvalid before last beat", 64'(bus.bvalid), 64'd0);
      @(posedge clock); #1;
    end
    bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    for (int s = 0; s < bStall; s++) begin
      @(negedge clock);
      checkOutput("bvalid stall", 64'(bus.bvalid), 64'd1);
      checkOutput("bresp stall", 64'(bus.bresp), 64'(expResp));
      checkOutput("arready in stall", 64'(bus.arready), 64'd0);
      @(posedge clock); #1;
    end
    bus.bready = 1'b1;
    @(negedge clock);
    checkOutput("bvalid", 64'(bus.bvalid), 64'd1);
    checkOutput("bresp", 64'(bus.bresp), 64'(expResp));
    bObs = bus.bresp;
    @(posedge clock); #1;
    bus.bready = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a = beatAddr(addr, size, burst, i);
      if (beatOk(a, burst)) begin
        idx = modelIdx(a);
        for (int b = 0; b < 8; b++)
          if (wrStrb[i][b]) model[idx][8*b +: 8] = wrData[i][8*b +: 8];
      end
    end
  endtask

  task automatic checkBeat(input logic [63:0] expData, input logic [1:0] expResp, input logic expLast);
    checkOutput("rvalid", 64'(bus.rvalid), 64'd1);
    checkOutput("rdata", bus.rdata, expData);
    checkOutput("rresp", 64'(bus.rresp), 64'(expResp));
    checkOutput("rlast", 64'(bus.rlast), 64'(expLast));
  endtask

  // Full read transaction with random rready stalls; called and returns just after a rising edge.
  task automatic axiRead(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input bit allowStall, output int arWait);
    logic [31:0] a;
    logic [63:0] expData;
    logic [1:0]  expResp;
    int stall;
    bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
    arWait = 0;
    @(negedge clock);
    while (!bus.arready && arWait < TIMEOUT) begin arWait++; @(negedge clock); end
    checkOutput("arready", 64'(bus.arready), 64'd1);
    @(posedge clock); #1;
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      a = beatAddr(addr, size, burst, i);
      expData = beatOk(a, burst) ? model[modelIdx(a)] : 64'd0;
      expResp = beatOk(a, burst) ? OKEY : SLVERR;
      stall = (allowStall && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (stall > 0) bus.rready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clock);
        checkBeat(expData, expResp, i == int'(len));
        @(posedge clock); #1;
      end
      bus.rready = 1'b1;
      @(negedge clock);
      checkBeat(expData, expResp, i == int'(len));
      rdObs[i] = bus.rdata;
      rdRespObs[i] = bus.rresp;
      @(posedge clock); #1;
    end
    bus.rready = 1'b0;
    @(negedge clock);
    checkOutput("rvalid after burst", 64'(bus.rvalid), 64'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkIdleOutputs("reset");
    @(posedge clock); #1;

    $display("[TB] preload all words");
    for (int i = 0; i < DEPTH; i++) begin wrData[i] = {$urandom, $urandom}; wrStrb[i] = 8'hFF; end
    applyStimulus(BASE, 8'd3, 3'd3, INCR, 0, waitCycles);

    $display("[TB] single write then read");
    wrData[0] = 64'h1122334455667788; wrStrb[0] = 8'hFF;
    applyStimulus(32'h8000_0010, 8'd0, 3'd3, INCR, 0, waitCycles);
    checkOutput("single bresp", 64'(bObs), 64'(OKEY));
    axiRead(32'h8000_0010, 8'd0, 3'd3, INCR, 1'b0, waitCycles);
    checkOutput("single rdata", rdObs[0], 64'h1122334455667788);

    $display("[TB] byte strobe");
    wrData[0] = 64'd0; wrStrb[0] = 8'hFF;
    applyStimulus(32'h8000_0008, 8'd0, 3'd3, INCR, 0, waitCycles);
    wrData[0] = 64'hAABBCCDDEEFF0011; wrStrb[0] = 8'h0C;
    applyStimulus(32'h8000_0008, 8'd0, 3'd3, INCR, 0, waitCycles);
    axiRead(32'h8000_0008, 8'd0, 3'd3, INCR, 1'b0, waitCycles);
    checkOutput("strobe rdata", rdObs[0], 64'h00000000EEFF0000);

    $display("[TB] INCR read past end of memory");
    axiRead(32'h8000_0010, 8'd3, 3'd3, INCR, 1'b0, waitCycles);
    checkOutput("end beat1 rresp", 64'(rdRespObs[1]), 64'(OKEY));
    checkOutput("end beat2 rresp", 64'(rdRespObs[2]), 64'(SLVERR));
    checkOutput("end beat3 rdata", rdObs[3], 64'd0);

    $display("[TB] simultaneous AW and AR, B stalled");
    bus.araddr = 32'h8000_0018; bus.arlen = 8'd0; bus.arsize = 3'd3; bus.arburst = INCR;
    bus.arvalid = 1'b1;
    wrData[0] = {$urandom, $urandom}; wrStrb[0] = 8'hFF;
    applyStimulus(32'h8000_0018, 8'd0, 3'd3, INCR, 5, waitCycles);
    axiRead(32'h8000_0018, 8'd0, 3'd3, INCR, 1'b0, waitCycles);
    checkOutput("AR wait after write", 64'(waitCycles), 64'd0);
    checkOutput("AR sees new data", rdObs[0], wrData[0]);

    $display("[TB] FIXED and WRAP bursts");
    for (int i = 0; i < 3; i++) begin wrData[i] = {$urandom, $urandom}; wrStrb[i] = 8'hFF; end
    applyStimulus(BASE, 8'd2, 3'd3, FIXED, 0, waitCycles);
    checkOutput("fixed bresp", 64'(bObs), 64'(OKEY));
    axiRead(BASE, 8'd0, 3'd3, INCR, 1'b0, waitCycles);
    checkOutput("fixed last beat", rdObs[0], wrData[2]);
    saved = model;
    for (int i = 0; i < 2; i++) begin wrData[i] = {$urandom, $urandom}; wrStrb[i] = 8'hFF; end
    applyStimulus(32'h8000_0008, 8'd1, 3'd3, WRAP, 1, waitCycles);
    checkOutput("wrap bresp", 64'(bObs), 64'(SLVERR));
    axiRead(BASE, 8'd3, 3'd3, INCR, 1'b0, waitCycles);
    for (int i = 0; i < DEPTH; i++) checkOutput("wrap no write", rdObs[i], saved[i]);
    axiRead(BASE, 8'd1, 3'd3, WRAP, 1'b0, waitCycles);

    $display("[TB] 32-bit address wrap and out-of-range write");
    axiRead(32'hFFFF_FFF8, 8'd1, 3'd3, INCR, 1'b0, waitCycles);
    wrData[0] = {$urandom, $urandom}; wrStrb[0] = 8'hFF;
    applyStimulus(32'h8000_0020, 8'd0, 3'd3, INCR, 0, waitCycles);
    checkOutput("oob bresp", 64'(bObs), 64'(SLVERR));

    $display("[TB] wvalid without AW");
    bus.wdata = {$urandom, $urandom}; bus.wstrb = 8'hFF; bus.wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("wready in idle", 64'(bus.wready), 64'd0);
      @(posedge clock); #1;
    end
    bus.wvalid = 1'b0;
    axiRead(BASE, 8'd3, 3'd3, INCR, 1'b0, waitCycles);

    $display("[TB] reset in the middle of a write burst");
    for (int i = 0; i < 4; i++) begin wrData[i] = {$urandom, $urandom}; wrStrb[i] = 8'hFF; end
    bus.awaddr = BASE; bus.awlen = 8'd3; bus.awsize = 3'd3; bus.awburst = INCR; bus.awvalid = 1'b1;
    @(negedge clock);
    checkOutput("rst awready", 64'(bus.awready), 64'd1);
    @(posedge clock); #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.wdata = wrData[i]; bus.wstrb = 8'hFF; bus.wvalid = 1'b1;
      @(negedge clock);
      checkOutput("rst wready", 64'(bus.wready), 64'd1);
      @(posedge clock); #1;
    end
    bus.wvalid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkIdleOutputs("after reset");
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("no bvalid after reset", 64'(bus.bvalid), 64'd0);
    @(posedge clock); #1;
    model[0] = wrData[0];
    model[1] = wrData[1];
    axiRead(BASE, 8'd3, 3'd3, INCR, 1'b0, waitCycles);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 40; t++) begin
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      addr  = BASE - 32'd16 + 32'(4 * $urandom_range(0, 15));
      len   = 8'($urandom_range(0, 4));
      size  = ($urandom_range(0, 1) == 1) ? 3'd3 : 3'd2;
      burst = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(len); i++) begin
          wrData[i] = {$urandom, $urandom};
          wrStrb[i] = 8'($urandom);
        end
        applyStimulus(addr, len, size, burst, int'($urandom_range(0, 2)), waitCycles);
      end else begin
        axiRead(addr, len, size, burst, 1'b1, waitCycles);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
